// File: rtl/serv_dbus_if.sv
// Wishbone classic data-bus master for the bit-serial core's load/store path.
// Accepts a single-cycle request and runs one bus cycle. Misaligned requests are trapped without a bus cycle.
module serv_dbus_if #(
    parameter int TIMEOUT       = 255,
    parameter bit WITH_MISALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    output logic        o_busy,
    output logic        o_rdy,
    output logic        o_err,
    output logic        o_misalign,
    output logic        o_load,
    output logic [31:0] o_rdat,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          load_q, load_d;
    logic          err_q, err_d;
    logic          mis_q, mis_d;

    logic          misalign;
    logic          term_err;
    logic          term_ack;
    logic          term_to;
    logic [3:0]    sel_req;
    logic [31:0]   dat_req;

    // Size 11 behaves like a word for both the alignment check and the lane selects.
    always_comb begin
        misalign = 1'b0;
        if (WITH_MISALIGN) begin
            misalign = ((i_size == 2'b01) && i_adr[0]) ||
                       (i_size[1] && (i_adr[1:0] != 2'b00));
        end
        case (i_size)
            2'b00: begin
                sel_req = 4'b0001 << i_adr[1:0];
                dat_req = {4{i_wdat[7:0]}};
            end
            2'b01: begin
                sel_req = i_adr[1] ? 4'b1100 : 4'b0011;
                dat_req = {2{i_wdat[15:0]}};
            end
            default: begin
                sel_req = 4'b1111;
                dat_req = i_wdat;
            end
        endcase
    end

    // Termination priority: err, then ack, then timeout.
    always_comb begin
        term_err = i_wb_err;
        term_ack = i_wb_ack && !i_wb_err;
        term_to  = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !i_wb_ack && !i_wb_err;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdat_q  <= rdat_d;
            load_q  <= load_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    state_d = misalign ? RESP : BUS;
                end
            end
            BUS: begin
                if (term_err || term_ack || term_to) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        sel_d  = sel_q;
        we_d   = we_q;
        rdat_d = rdat_q;
        load_d = load_q;
        err_d  = err_q;
        mis_d  = mis_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_req) begin
                    load_d = 1'b0;
                    err_d  = 1'b0;
                    mis_d  = misalign;
                    // A trapped request leaves the bus-facing registers untouched.
                    if (!misalign) begin
                        adr_d = {i_adr[31:2], 2'b00};
                        dat_d = dat_req;
                        sel_d = sel_req;
                        we_d  = i_we;
                    end
                end
            end
            BUS: begin
                if (term_err) begin
                    err_d = 1'b1;
                end else if (term_ack) begin
                    load_d = !we_q;
                    if (!we_q) begin
                        rdat_d = i_wb_rdt;
                    end
                end else if (term_to) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        o_busy     = (state_q != IDLE);
        o_wb_cyc   = (state_q == BUS);
        o_rdy      = (state_q == RESP);
        o_load     = (state_q == RESP) && load_q;
        o_err      = (state_q == RESP) && err_q;
        o_misalign = (state_q == RESP) && mis_q;
    end

    assign o_rdat   = rdat_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;

endmodule

// File: tb/tb_serv_dbus_if.sv
// Directed bench for serv_dbus_if with TIMEOUT = 4: loads, stores, misalignment, timeout, err/ack, reset.
module tb_serv_dbus_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_we;
    logic [1:0]  i_size;
    logic [31:0] i_adr, i_wdat;
    logic        o_busy, o_rdy, o_err, o_misalign, o_load;
    logic [31:0] o_rdat, o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc;
    logic [31:0] i_wb_rdt;
    logic        i_wb_ack, i_wb_err;

    always #5 clk = ~clk;

    serv_dbus_if #(.TIMEOUT(4), .WITH_MISALIGN(1'b1)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_size     (i_size),
        .i_adr      (i_adr),
        .i_wdat     (i_wdat),
        .o_busy     (o_busy),
        .o_rdy      (o_rdy),
        .o_err      (o_err),
        .o_misalign (o_misalign),
        .o_load     (o_load),
        .o_rdat     (o_rdat),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .i_wb_err   (i_wb_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Results of the most recent transaction
    int          r_cyc, r_rdy, r_lat;
    logic        r_load, r_err, r_mis, r_done;
    logic [31:0] r_rdat, s_adr, s_dat;
    logic [3:0]  s_sel;
    logic        s_we;

    // Issues one request at a negedge, answers after wait_n BUS cycles, observes until 3 cycles past o_rdy.
    task automatic xfer(input string name, input logic we, input logic [1:0] size,
                        input logic [31:0] adr, input logic [31:0] wdat, input int wait_n,
                        input bit do_ack, input bit do_err, input logic [31:0] rdt, input bit inject);
        r_cyc = 0; r_rdy = 0; r_lat = -1;
        r_load = 1'b0; r_err = 1'b0; r_mis = 1'b0; r_done = 1'b0; r_rdat = '0;
        s_adr = '0; s_dat = '0; s_sel = '0; s_we = 1'b0;
        i_req = 1'b1; i_we = we; i_size = size; i_adr = adr; i_wdat = wdat; i_wb_rdt = rdt;
        for (int i = 1; i <= 40 && !r_done; i++) begin
            @(negedge clk);
            if (o_wb_cyc) begin
                r_cyc++;
                if (r_cyc == 1) begin
                    s_adr = o_wb_adr; s_dat = o_wb_dat; s_sel = o_wb_sel; s_we = o_wb_we;
                end
            end
            i_req    = inject && o_wb_cyc && (r_cyc == 1);
            i_wb_ack = o_wb_cyc && do_ack && (r_cyc == wait_n + 1);
            i_wb_err = o_wb_cyc && do_err && (r_cyc == wait_n + 1);
            if (o_rdy) begin
                r_rdy++;
                r_lat  = i;
                r_load = o_load; r_err = o_err; r_mis = o_misalign; r_rdat = o_rdat;
            end
            if (r_lat > 0 && i >= r_lat + 3) r_done = 1'b1;
        end
        i_req = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        check({name, ".done"}, 32'(r_done), 32'd1);
        $display("%s: cyc=%0d rdy=%0d lat=%0d load=%0b err=%0b mis=%0b rdat=%08h",
                 name, r_cyc, r_rdy, r_lat, r_load, r_err, r_mis, r_rdat);
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_adr = '0; i_wdat = '0;
        i_wb_rdt = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(o_busy), 32'd0);
        check("rst.cyc",  32'(o_wb_cyc), 32'd0);
        check("rst.rdy",  32'(o_rdy), 32'd0);
        check("rst.rdat", o_rdat, 32'h0);
        check("rst.adr",  o_wb_adr, 32'h0);
        check("rst.sel",  32'(o_wb_sel), 32'h0);
        check("rst.dat",  o_wb_dat, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load, 3 wait cycles then ack
        xfer("wload", 1'b0, 2'b10, 32'h100, 32'h0, 3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);
        check("wload.sel",  32'(s_sel), 32'hF);
        check("wload.adr",  s_adr, 32'h100);
        check("wload.cyc",  32'(r_cyc), 32'd4);
        check("wload.rdy",  32'(r_rdy), 32'd1);
        check("wload.lat",  32'(r_lat), 32'd5);
        check("wload.load", 32'(r_load), 32'd1);
        check("wload.err",  32'(r_err), 32'd0);
        check("wload.rdat", r_rdat, 32'hDEADBEEF);

        // Byte load at lane 1: raw word is returned
        xfer("bload", 1'b0, 2'b00, 32'h001, 32'h0, 0, 1'b1, 1'b0, 32'h11223344, 1'b0);
        check("bload.sel",  32'(s_sel), 32'h2);
        check("bload.we",   32'(s_we), 32'd0);
        check("bload.rdat", r_rdat, 32'h11223344);

        // Byte store of 0x5A at 0x203, immediate ack: minimum latency
        xfer("bstore", 1'b1, 2'b00, 32'h203, 32'h0000005A, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0);
        check("bstore.adr",  s_adr, 32'h200);
        check("bstore.sel",  32'(s_sel), 32'h8);
        check("bstore.dat",  s_dat, 32'h5A5A5A5A);
        check("bstore.we",   32'(s_we), 32'd1);
        check("bstore.rdy",  32'(r_rdy), 32'd1);
        check("bstore.lat",  32'(r_lat), 32'd2);
        check("bstore.load", 32'(r_load), 32'd0);
        check("bstore.rdat", r_rdat, 32'h11223344);

        // Half store at 0x102
        xfer("hstore", 1'b1, 2'b01, 32'h102, 32'h00001234, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        check("hstore.sel", 32'(s_sel), 32'hC);
        check("hstore.dat", s_dat, 32'h12341234);
        check("hstore.adr", s_adr, 32'h100);

        // Misaligned half load at 0x101: no bus cycle
        xfer("hmis", 1'b0, 2'b01, 32'h101, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("hmis.cyc",  32'(r_cyc), 32'd0);
        check("hmis.rdy",  32'(r_rdy), 32'd1);
        check("hmis.lat",  32'(r_lat), 32'd1);
        check("hmis.mis",  32'(r_mis), 32'd1);
        check("hmis.load", 32'(r_load), 32'd0);

        // No slave response: timeout after 4 BUS cycles
        xfer("tmo", 1'b0, 2'b10, 32'h300, 32'h0, 0, 1'b0, 1'b0, 32'h55555555, 1'b0);
        check("tmo.cyc",  32'(r_cyc), 32'd4);
        check("tmo.rdy",  32'(r_rdy), 32'd1);
        check("tmo.lat",  32'(r_lat), 32'd5);
        check("tmo.err",  32'(r_err), 32'd1);
        check("tmo.load", 32'(r_load), 32'd0);
        check("tmo.rdat", r_rdat, 32'h11223344);

        // ack and err together, plus a stray request during BUS
        xfer("ackerr", 1'b0, 2'b10, 32'h104, 32'h0, 1, 1'b1, 1'b1, 32'h99999999, 1'b1);
        check("ackerr.cyc",  32'(r_cyc), 32'd2);
        check("ackerr.rdy",  32'(r_rdy), 32'd1);
        check("ackerr.err",  32'(r_err), 32'd1);
        check("ackerr.load", 32'(r_load), 32'd0);
        check("ackerr.busy", 32'(o_busy), 32'd0);

        // Reset in the middle of a bus cycle
        i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_adr = 32'h80;
        @(negedge clk);
        i_req = 1'b0;
        check("rstbus.cyc_before", 32'(o_wb_cyc), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstbus.cyc",  32'(o_wb_cyc), 32'd0);
        check("rstbus.busy", 32'(o_busy), 32'd0);
        check("rstbus.rdy",  32'(o_rdy), 32'd0);
        @(negedge clk);
        check("rstbus.rdy_after", 32'(o_rdy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        xfer("postrst", 1'b0, 2'b10, 32'h40, 32'h0, 0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0);
        check("postrst.rdy",  32'(r_rdy), 32'd1);
        check("postrst.load", 32'(r_load), 32'd1);
        check("postrst.rdat", r_rdat, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/serv_dbus_if.md
# serv_dbus_if

Data-bus master for the bit-serial core's load/store path, sitting between the bufreg2 data register and the external Wishbone data bus. It accepts a single-cycle request carrying the address, size and store data, and issues one Wishbone classic cycle with byte-lane selects and replicated store data. It returns the raw 32-bit read word together with a one-cycle load strobe that drives bufreg2's `i_load`/`i_dat`. It also flags misaligned accesses, bus errors and bus timeouts to the control logic.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles `o_wb_cyc` may stay high without `i_wb_ack`/`i_wb_err` before the cycle is aborted; 0 disables the timeout.
- `WITH_MISALIGN`, 1: when 1, misaligned requests are trapped; when 0, address bits [1:0] are ignored for the alignment check.

Ports:
- `i_clk`  in  1  clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_req`  in  1  start request; sampled only in IDLE.
- `i_we`  in  1  1 = store, 0 = load.
- `i_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `i_adr`  in  32  byte address.
- `i_wdat`  in  32  store data, right-aligned (from bufreg2 `o_dat`).
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_rdy`  out  1  one-cycle completion pulse.
- `o_err`  out  1  one-cycle pulse coincident with `o_rdy` on bus error or timeout.
- `o_misalign`  out  1  one-cycle pulse coincident with `o_rdy` for a trapped misaligned request.
- `o_load`  out  1  one-cycle pulse, coincident with `o_rdy`, on a successful load only.
- `o_rdat`  out  32  captured read word with raw lanes; bufreg2 selects the byte lane.
- `o_wb_adr`  out  32  word address, with bits [1:0] forced to 0.
- `o_wb_dat`  out  32  store data.
- `o_wb_sel`  out  4  byte enables.
- `o_wb_we`  out  1  write enable.
- `o_wb_cyc`  out  1  cycle/strobe.
- `i_wb_rdt`  in  32  read data.
- `i_wb_ack`  in  1  acknowledge.
- `i_wb_err`  in  1  error termination.

## Operation
- States: IDLE, BUS, RESP.
  - IDLE → BUS on `i_req` with an aligned request.
  - IDLE → RESP on `i_req` with a misaligned request (`WITH_MISALIGN` = 1).
  - BUS → RESP on ack, err or timeout.
  - RESP → IDLE unconditionally.
- Misalignment rule: half with `adr[0]` = 1; word (or size 11) with `adr[1:0]` ≠ 0. A misaligned request issues no bus cycle.
- On accept, register the following and hold them constant throughout BUS:
  - `o_wb_adr` = {`adr[31:2]`, 2'b00}.
  - `o_wb_we` = `i_we`.
  - `o_wb_sel`:
    - Byte: 4'b0001 << `adr[1:0]`.
    - Half: `adr[1]` ? 4'b1100 : 4'b0011.
    - Word: 4'b1111.
  - `o_wb_dat`:
    - Byte: {4{`wdat[7:0]`}}.
    - Half: {2{`wdat[15:0]`}}.
    - Word: `wdat`.
  - `o_wb_sel` is also driven for loads.
- BUS: `o_wb_cyc` = 1. A timeout counter clears on entry and increments each BUS cycle without termination. Timeout fires when the counter reaches `TIMEOUT` − 1 and no ack/err is present in that cycle.
- Termination priority: `i_wb_err` > `i_wb_ack` > timeout.
- On ack of a load, capture `o_rdat` ← `i_wb_rdt`. `o_rdat` otherwise holds its value and is not cleared on error.
- RESP: `o_rdy` = 1. `o_load` = 1 only for a load terminated by ack. `o_err` = 1 for err or timeout. `o_misalign` = 1 for a trapped misaligned request.
- `i_req` in BUS or RESP is ignored; it is not queued.
- `i_wb_ack`/`i_wb_err` while `o_wb_cyc` = 0 are ignored.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - State = IDLE.
  - All outputs = 0, including `o_rdat`, `o_wb_adr`, `o_wb_dat` and `o_wb_sel`.
  - Timeout counter = 0.
- Reset asserted mid-BUS drops `o_wb_cyc` immediately, with no `o_rdy` pulse.
- With `i_req` sampled at edge 0:
  - `o_wb_cyc` is high from edge 0.
  - An ack sampled at edge k (k ≥ 1) drops `o_wb_cyc` at edge k.
  - `o_rdy`/`o_load` are high for exactly the cycle between edges k and k+1.
- Minimum request-to-`o_rdy` latency is 2 edges. Back-to-back: the next `i_req` is accepted at edge k+2 at the earliest.
- Misaligned request: `o_rdy` and `o_misalign` are high in the cycle after edge 0; `o_wb_cyc` never rises.
- Timeout: `o_wb_cyc` is high for exactly `TIMEOUT` cycles, then `o_rdy` and `o_err` pulse.
- `o_rdat` is valid from the `o_load` cycle until the next successful load.

## Test plan
- Word load at 0x100, ack after 3 wait cycles → `o_wb_sel` = F and `o_wb_adr` = 0x100. `o_wb_cyc` is high for 4 cycles. `o_load` and `o_rdy` pulse once, with `o_rdat` = the driven `i_wb_rdt` (0xDEADBEEF).
- Byte store of 0x5A at 0x203 → `o_wb_adr` = 0x200, `o_wb_sel` = 4'b1000, `o_wb_dat` = 0x5A5A5A5A, `o_wb_we` = 1. `o_rdy` pulses with `o_load` = 0.
- Half store at 0x102 → `o_wb_sel` = 4'b1100. A half load at 0x101 → no `o_wb_cyc`; `o_rdy` and `o_misalign` pulse in the cycle after the request.
- `TIMEOUT` = 4, no slave response → `o_wb_cyc` is high for exactly 4 cycles, then `o_rdy` and `o_err` pulse; `o_load` = 0 and `o_rdat` is unchanged.
- `i_wb_ack` and `i_wb_err` asserted together on a load → `o_err` = 1 and `o_load` = 0. An `i_req` pulse during BUS is ignored, so exactly one bus cycle occurs.
- `i_rst_n` pulled low mid-BUS → `o_wb_cyc` and `o_busy` drop immediately with no `o_rdy`. After release, a new load completes normally.
